button_conditioner: RTL and testbench

- Multi-channel successor to the single-bit pushbutton debouncer, in the input path between board buttons/switches and game_logic.
- Each channel has:
  - a 2-flop synchroniser;
  - a parametrised stability filter;
  - registered press/release edge pulses;
  - an optional hold-to-auto-repeat pulse train, so a held direction button steps the player repeatedly.
- All channels run in parallel and are independent.

---
 rtl/button_conditioner.sv | 142 ++++++++++++++
 tb/tb_button_conditioner.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - multi-channel button synchroniser, debounce filter, edge pulses and auto-repeat
module button_conditioner #(
    parameter int NUM_CH          = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_RATE     = 2500000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] noisy_in,
    input  logic [NUM_CH-1:0] repeat_en,
    output logic [NUM_CH-1:0] clean_out,
    output logic [NUM_CH-1:0] press_pulse,
    output logic [NUM_CH-1:0] release_pulse,
    output logic [NUM_CH-1:0] repeat_pulse,
    output logic [NUM_CH-1:0] action_pulse
);

    localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic          sync1;
        logic          sync2;
        logic          clean;
        logic          press_q;
        logic          rel_q;
        logic          rep_q;
        logic [CW-1:0] count;
        logic          flip;
        rep_state_t    state;
        rep_state_t    state_n;
        logic [RW-1:0] rcount;
        logic [RW-1:0] rcount_n;
        logic          rep_n;

        // flip marks the edge on which the filter accepts the new level
        assign flip = (sync2 != clean) && (count == DEB_LAST);

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                sync1 <= 1'b0;
                sync2 <= 1'b0;
            end else begin
                sync1 <= noisy_in[i];
                sync2 <= sync1;
            end
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                clean   <= 1'b0;
                count   <= '0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                press_q <= flip & sync2;
                rel_q   <= flip & ~sync2;
                if (sync2 == clean) begin
                    count <= '0;
                end else if (flip) begin
                    clean <= sync2;
                    count <= '0;
                end else begin
                    count <= count + CW'(1);
                end
            end
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                state  <= IDLE;
                rcount <= '0;
                rep_q  <= 1'b0;
            end else begin
                state  <= state_n;
                rcount <= rcount_n;
                rep_q  <= rep_n;
            end
        end

        // release or disable wins over any counter expiry on the same edge
        always_comb begin
            state_n  = state;
            rcount_n = rcount;
            rep_n    = 1'b0;
            if ((flip && !sync2) || !repeat_en[i]) begin
                state_n  = IDLE;
                rcount_n = '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (flip && sync2) begin
                            state_n  = DELAY;
                            rcount_n = '0;
                        end
                    end
                    DELAY: begin
                        if (rcount == DELAY_LAST) begin
                            rep_n    = 1'b1;
                            state_n  = REPEAT;
                            rcount_n = '0;
                        end else begin
                            rcount_n = rcount + RW'(1);
                        end
                    end
                    REPEAT: begin
                        if (rcount == RATE_LAST) begin
                            rep_n    = 1'b1;
                            rcount_n = '0;
                        end else begin
                            rcount_n = rcount + RW'(1);
                        end
                    end
                    default: begin
                        state_n  = IDLE;
                        rcount_n = '0;
                    end
                endcase
            end
        end

        assign clean_out[i]     = clean;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = rel_q;
        assign repeat_pulse[i]  = rep_q;
    end

    assign action_pulse = press_pulse | repeat_pulse;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - self-checking bench for button_conditioner against a timing-based model
module tb_button_conditioner;

    localparam int NCH = 5;
    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RR  = 3;

    logic           clock;
    logic           reset;
    logic [NCH-1:0] noisy_in;
    logic [NCH-1:0] repeat_en;
    logic [NCH-1:0] clean_out;
    logic [NCH-1:0] press_pulse;
    logic [NCH-1:0] release_pulse;
    logic [NCH-1:0] repeat_pulse;
    logic [NCH-1:0] action_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    button_conditioner #(
        .NUM_CH(NCH), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clock(clock),
        .reset(reset),
        .noisy_in(noisy_in),
        .repeat_en(repeat_en),
        .clean_out(clean_out),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .repeat_pulse(repeat_pulse),
        .action_pulse(action_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: input seen two edges late, level accepted after DEB consecutive
    // differing samples, repeats fire at elapsed times RD, RD+RR, ... after press.
    bit             m_s1   [NCH];
    bit             m_s2   [NCH];
    bit             m_lvl  [NCH];
    bit             armed  [NCH];
    int             run    [NCH];
    int             since  [NCH];
    logic [NCH-1:0] e_clean, e_press, e_rel, e_rep;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; armed[i] = 0;
                run[i] = 0; since[i] = 0;
            end
            e_clean = '0; e_press = '0; e_rel = '0; e_rep = '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                bit rise, fall, rep;
                rise = 0; fall = 0; rep = 0;
                if (m_s2[i] != m_lvl[i]) begin
                    run[i]++;
                    if (run[i] == DEB) begin
                        run[i]   = 0;
                        m_lvl[i] = m_s2[i];
                        rise     = m_s2[i];
                        fall     = !m_s2[i];
                    end
                end else begin
                    run[i] = 0;
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = noisy_in[i];
                if (rise) begin
                    armed[i] = repeat_en[i];
                    since[i] = 0;
                end else if (fall || !repeat_en[i]) begin
                    armed[i] = 0;
                end else if (armed[i]) begin
                    since[i]++;
                    rep = (since[i] >= RD) && (((since[i] - RD) % RR) == 0);
                end
                e_clean[i] = m_lvl[i];
                e_press[i] = rise;
                e_rel[i]   = fall;
                e_rep[i]   = rep;
            end
        end
    end

    task automatic chk(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            chk("model_clean",   clean_out,     e_clean);
            chk("model_press",   press_pulse,   e_press);
            chk("model_release", release_pulse, e_rel);
            chk("model_repeat",  repeat_pulse,  e_rep);
            chk("model_action",  action_pulse,  e_press | e_rep);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        reset     = 1'b1;
        noisy_in  = '0;
        repeat_en = '0;
        @(negedge clock);
        chk("reset_clean", clean_out, 5'b00000);
        chk("reset_pulses", press_pulse | release_pulse | repeat_pulse, 5'b00000);
        reset = 1'b0;
        tick(2);

        // basic press/release
        noisy_in[0] = 1'b1;
        tick(5);
        chk("t1_clean_before", clean_out, 5'b00000);
        tick(1);
        chk("t1_clean_rise", clean_out, 5'b00001);
        chk("t1_press", press_pulse, 5'b00001);
        chk("t1_action", action_pulse, 5'b00001);
        tick(1);
        chk("t1_press_single", press_pulse, 5'b00000);
        noisy_in[0] = 1'b0;
        tick(5);
        chk("t1_no_release_yet", release_pulse, 5'b00000);
        tick(1);
        chk("t1_release", release_pulse, 5'b00001);
        chk("t1_clean_fall", clean_out, 5'b00000);
        tick(4);

        // bounce rejection
        for (int j = 0; j < 10; j++) begin
            noisy_in[2] = ~noisy_in[2];
            tick(2);
            chk("t2_bounce_clean", clean_out, 5'b00000);
        end
        noisy_in[2] = 1'b1;
        tick(5);
        chk("t2_clean_before", clean_out, 5'b00000);
        tick(1);
        chk("t2_clean_rise", clean_out, 5'b00100);
        noisy_in[2] = 1'b0;
        tick(10);

        // auto-repeat, release coinciding with counter expiry
        repeat_en[1] = 1'b1;
        noisy_in[1]  = 1'b1;
        tick(6);
        chk("t3_press", press_pulse, 5'b00010);
        chk("t3_no_rep_on_press", repeat_pulse, 5'b00000);
        tick(9);
        chk("t3_rep_early", repeat_pulse, 5'b00000);
        tick(1);
        chk("t3_rep1", repeat_pulse, 5'b00010);
        chk("t3_rep1_action", action_pulse, 5'b00010);
        tick(3);
        chk("t3_rep2", repeat_pulse, 5'b00010);
        tick(3);
        chk("t3_rep3", repeat_pulse, 5'b00010);
        noisy_in[1] = 1'b0;
        tick(3);
        chk("t3_rep4", repeat_pulse, 5'b00010);
        tick(3);
        chk("t3_release", release_pulse, 5'b00010);
        chk("t3_no_rep_on_release", repeat_pulse, 5'b00000);
        tick(3);
        chk("t3_no_rep_after", repeat_pulse, 5'b00000);
        tick(6);

        // disable mid-hold
        noisy_in[1] = 1'b1;
        tick(16);
        chk("t4_rep1", repeat_pulse, 5'b00010);
        tick(3);
        chk("t4_rep2", repeat_pulse, 5'b00010);
        repeat_en[1] = 1'b0;
        tick(1);
        repeat_en[1] = 1'b1;
        for (int j = 0; j < 12; j++) begin
            tick(1);
            chk("t4_no_rep_held", repeat_pulse, 5'b00000);
        end
        noisy_in[1] = 1'b0;
        tick(10);
        noisy_in[1] = 1'b1;
        tick(6);
        chk("t4_repress", press_pulse, 5'b00010);
        tick(9);
        chk("t4_rep_early", repeat_pulse, 5'b00000);
        tick(1);
        chk("t4_rep_resumed", repeat_pulse, 5'b00010);

        // async reset while all channels repeat
        noisy_in  = 5'b11111;
        repeat_en = 5'b11111;
        tick(22);
        #1 reset = 1'b1;
        #1;
        chk("t5_async_clean", clean_out, 5'b00000);
        chk("t5_async_pulses", press_pulse | release_pulse | repeat_pulse | action_pulse, 5'b00000);
        tick(2);
        reset = 1'b0;
        tick(5);
        chk("t5_no_press_yet", press_pulse, 5'b00000);
        tick(1);
        chk("t5_press_all", press_pulse, 5'b11111);
        chk("t5_clean_all", clean_out, 5'b11111);

        // simultaneous press on ch3 and release on ch4
        repeat_en   = '0;
        noisy_in[3] = 1'b0;
        tick(10);
        chk("t6_ch3_low", clean_out, 5'b10111);
        noisy_in[3] = 1'b1;
        noisy_in[4] = 1'b0;
        tick(6);
        chk("t6_press", press_pulse, 5'b01000);
        chk("t6_release", release_pulse, 5'b10000);
        chk("t6_clean", clean_out, 5'b01111);
        tick(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
